alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter CODE, default 3'b101, is the disarm code.
REQ-002 Parameter SIREN_CYCLES, default 8, is the siren duration per detection, in cycles.
REQ-003 Parameter MAX_TRIES, default 3, is the number of consecutive wrong codes that triggers lockout.
REQ-004 Parameter LOCK_CYCLES, default 16, is the lockout duration, in cycles.
REQ-005 The module SHALL have the following ports; clock and reset come first.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- arm_req  input  1  arm request pulse.
- alarm_bit  input  1  high while the lamp-sequence detector reports LAMP1->LAMP2->LAMP3.
- code_in  input  3  keypad code.
- code_valid  input  1  qualifies code_in for one cycle.
- det_reset  output  1  holds the sequence detector in IDLE.
- armed  output  1  controller is not DISARMED.
- siren  output  1  siren drive.
- locked  output  1  controller is in LOCKOUT.
- event_cnt  output  4  detections since reset, saturating.

Function
REQ-006 The FSM SHALL have four states: DISARMED, ARMED, SIREN, LOCKOUT.
REQ-007 DISARMED: arm_req -> ARMED; code_valid and alarm_bit are ignored; tries held at 0.
REQ-008 ARMED: alarm_bit -> SIREN, timer loaded with SIREN_CYCLES-1, event_cnt+1.
REQ-009 SIREN: timer decrements each cycle; at timer==0 with no other event -> ARMED, so the siren lasts exactly SIREN_CYCLES cycles.
REQ-010 SIREN: alarm_bit high -> timer reloaded with SIREN_CYCLES-1, event_cnt+1, stay in SIREN.
REQ-011 ARMED or SIREN: code_valid with code_in==CODE -> DISARMED, tries cleared, timer cleared.
REQ-012 ARMED or SIREN: code_valid with code_in!=CODE -> tries+1; when tries reaches MAX_TRIES -> LOCKOUT, timer loaded with LOCK_CYCLES-1.
REQ-013 LOCKOUT: code_valid, arm_req and alarm_bit are ignored; at timer==0 -> ARMED, tries cleared.
REQ-014 Priority in one cycle, highest first: correct code, wrong code, alarm_bit, timer expiry.
REQ-015 arm_req is ignored in every state except DISARMED.
REQ-016 event_cnt SHALL saturate at 15 and never wrap.
REQ-017 tries SHALL be internal, 2 bits wide, and saturate at MAX_TRIES.
REQ-018 Outputs are Moore decodes of the registered state, valid the cycle after the transition edge:
- armed = state!=DISARMED
- siren = state is SIREN or LOCKOUT
- locked = state==LOCKOUT
- det_reset = state is DISARMED or LOCKOUT
REQ-019 Latency from input sample edge to output change SHALL be 1 cycle.

Reset
REQ-020 Asserting reset SHALL immediately, without waiting for a clock edge, force state=DISARMED, timer=0, tries=0, event_cnt=0.
REQ-021 While reset is asserted, outputs SHALL be armed=0, siren=0, locked=0, det_reset=1, event_cnt=0.
REQ-022 Reset asserted mid-SIREN or mid-LOCKOUT SHALL abort the timer with no residual siren.
REQ-023 After reset deassertion, the first clock edge SHALL evaluate DISARMED transitions.

Structure
REQ-024 Package alarm_pkg SHALL hold the state enum (2 bits), the default CODE and the width constants; both the RTL and the bench import it.
REQ-025 Sub-module alarm_timer SHALL be a loadable down-counter with inputs load, load_val and clear, and output zero; alarm_ctrl instantiates it once, shared by SIREN and LOCKOUT.
REQ-026 alarm_ctrl SHALL drive det_reset into the sequence detector's reset and take alarm_bit from the detector output.

Verification
REQ-027 arm_req pulse, then alarm_bit for 1 cycle -> siren=1 for exactly 8 cycles, then ARMED, event_cnt=1.
REQ-028 In SIREN, alarm_bit again at siren cycle 5 -> siren extends to 5+8 cycles total, event_cnt=2.
REQ-029 ARMED, code_in=3'b101 with code_valid -> DISARMED next cycle, armed=0, det_reset=1.
REQ-030 ARMED, three wrong codes (3'b000) -> locked=1 and siren=1 for 16 cycles, correct code during lockout ignored, then ARMED with armed=1 and locked=0.
REQ-031 Same cycle as alarm_bit, correct code asserted -> DISARMED, siren stays 0, event_cnt unchanged.
REQ-032 Reset asserted asynchronously mid-SIREN, between clock edges -> siren=0 and event_cnt=0 before the next edge; 20 alarm_bit events after re-arming -> event_cnt=15.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller and its timer.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_SIREN    = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  localparam int                CODE_W       = 3;
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 3'b101;
  localparam int                EVENT_W      = 4;
  localparam int                TRIES_W      = 2;
  localparam int                TIMER_W      = 8;

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the siren and lockout phases.
// Counts down to zero and holds there; clear wins over load.
module alarm_timer
  import alarm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clear,
  output logic               zero
);

  logic [TIMER_W-1:0] cnt;

  // Count register: clear, reload, or decrement toward zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Intrusion alarm controller: arms on request, sounds the siren on each
// detection from the lamp-sequence detector, disarms on the keypad code and
// locks out after repeated wrong codes. Outputs are Moore decodes of state.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter logic [CODE_W-1:0] CODE         = DEFAULT_CODE,
  parameter int                SIREN_CYCLES = 8,
  parameter int                MAX_TRIES    = 3,
  parameter int                LOCK_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_req,
  input  logic               alarm_bit,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  output logic               det_reset,
  output logic               armed,
  output logic               siren,
  output logic               locked,
  output logic [EVENT_W-1:0] event_cnt
);

  localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX  = TRIES_W'(MAX_TRIES);
  localparam logic [EVENT_W-1:0] EVENT_MAX  = {EVENT_W{1'b1}};

  function automatic logic [EVENT_W-1:0] sat_inc_event(input logic [EVENT_W-1:0] v);
    return (v == EVENT_MAX) ? v : v + EVENT_W'(1);
  endfunction

  function automatic logic [TRIES_W-1:0] sat_inc_tries(input logic [TRIES_W-1:0] v);
    return (v >= TRIES_MAX) ? TRIES_MAX : v + TRIES_W'(1);
  endfunction

  state_t             state, state_n;
  logic [TRIES_W-1:0] tries, tries_n, tries_inc;
  logic [EVENT_W-1:0] event_n;
  logic               t_load, t_clear, t_zero;
  logic [TIMER_W-1:0] t_val;
  logic               code_ok, code_bad;

  assign code_ok   = code_valid && (code_in == CODE);
  assign code_bad  = code_valid && (code_in != CODE);
  assign tries_inc = sat_inc_tries(tries);

  alarm_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .clear    (t_clear),
    .zero     (t_zero)
  );

  // State, wrong-code tally and detection count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_DISARMED;
      tries     <= '0;
      event_cnt <= '0;
    end else begin
      state     <= state_n;
      tries     <= tries_n;
      event_cnt <= event_n;
    end
  end

  // Next-state logic; within one cycle only the highest-priority event acts:
  // correct code, wrong code, detection, timer expiry.
  always_comb begin
    state_n = state;
    tries_n = tries;
    event_n = event_cnt;
    t_load  = 1'b0;
    t_val   = '0;
    t_clear = 1'b0;
    case (state)
      ST_DISARMED: begin
        tries_n = '0;
        if (arm_req) state_n = ST_ARMED;
      end
      ST_ARMED, ST_SIREN: begin
        if (code_ok) begin
          state_n = ST_DISARMED;
          tries_n = '0;
          t_clear = 1'b1;
        end else if (code_bad) begin
          tries_n = tries_inc;
          if (tries_inc == TRIES_MAX) begin
            state_n = ST_LOCKOUT;
            t_load  = 1'b1;
            t_val   = LOCK_LOAD;
          end
        end else if (alarm_bit) begin
          state_n = ST_SIREN;
          t_load  = 1'b1;
          t_val   = SIREN_LOAD;
          event_n = sat_inc_event(event_cnt);
        end else if (state == ST_SIREN && t_zero) begin
          state_n = ST_ARMED;
        end
      end
      ST_LOCKOUT: begin
        if (t_zero) begin
          state_n = ST_ARMED;
          tries_n = '0;
        end
      end
      default: state_n = ST_DISARMED;
    endcase
  end

  assign armed     = (state != ST_DISARMED);
  assign siren     = (state == ST_SIREN) || (state == ST_LOCKOUT);
  assign locked    = (state == ST_LOCKOUT);
  assign det_reset = (state == ST_DISARMED) || (state == ST_LOCKOUT);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios followed by random traffic, all
// compared cycle by cycle against a behavioural model of the alarm rules.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int SIREN_N = 8;
  localparam int TRIES_N = 3;
  localparam int LOCK_N  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm_req, alarm_bit, code_valid;
  logic [2:0] code_in;
  logic       det_reset, armed, siren, locked;
  logic [3:0] event_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  // Behavioural model: remaining siren / lockout cycles, wrong-code tally.
  bit m_on;
  int m_sir, m_lock, m_tries, m_ev;

  alarm_ctrl #(
    .CODE(DEFAULT_CODE), .SIREN_CYCLES(SIREN_N), .MAX_TRIES(TRIES_N), .LOCK_CYCLES(LOCK_N)
  ) dut (
    .clk(clk), .reset(reset), .arm_req(arm_req), .alarm_bit(alarm_bit),
    .code_in(code_in), .code_valid(code_valid), .det_reset(det_reset),
    .armed(armed), .siren(siren), .locked(locked), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_sir = 0; m_lock = 0; m_tries = 0; m_ev = 0;
  endtask

  task automatic model_step(input bit a, input bit al, input bit cv, input logic [2:0] c);
    if (!m_on) begin
      m_tries = 0;
      if (a) m_on = 1'b1;
      return;
    end
    if (m_lock > 0) begin
      if (m_lock == 1) begin m_lock = 0; m_tries = 0; end
      else m_lock--;
      return;
    end
    if (cv && c == DEFAULT_CODE) begin
      m_on = 1'b0; m_sir = 0; m_tries = 0;
      return;
    end
    if (cv) begin
      m_tries = (m_tries + 1 > TRIES_N) ? TRIES_N : m_tries + 1;
      if (m_tries == TRIES_N) begin
        m_sir = 0; m_lock = LOCK_N;
      end else if (m_sir > 1) begin
        m_sir--;
      end
      return;
    end
    if (al) begin
      m_sir = SIREN_N;
      m_ev = (m_ev < 15) ? m_ev + 1 : 15;
      return;
    end
    if (m_sir > 0) m_sir--;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".armed"},     armed,     m_on);
    chk({tag, ".siren"},     siren,     (m_sir > 0) || (m_lock > 0));
    chk({tag, ".locked"},    locked,    m_lock > 0);
    chk({tag, ".det_reset"}, det_reset, !m_on || (m_lock > 0));
    chk({tag, ".event_cnt"}, event_cnt, m_ev);
  endtask

  task automatic step(input bit a, input bit al, input bit cv, input logic [2:0] c,
                      input string tag);
    arm_req = a; alarm_bit = al; code_valid = cv; code_in = c;
    @(posedge clk);
    model_step(a, al, cv, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    arm_req = 0; alarm_bit = 0; code_valid = 0; code_in = 3'b000;
    reset = 1'b1;
    model_reset();
    #1;
    chk({tag, ".rst_armed"}, armed, 1'b0);
    chk({tag, ".rst_siren"}, siren, 1'b0);
    chk({tag, ".rst_det"},   det_reset, 1'b1);
    chk({tag, ".rst_ev"},    event_cnt, 4'd0);
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; arm_req = 0; alarm_bit = 0; code_valid = 0; code_in = 3'b000;
    #2;
    do_reset("init");
    step(0, 1, 1, DEFAULT_CODE, "disarmed_ignores");

    // Single detection: siren for exactly SIREN_N cycles.
    step(1, 0, 0, 3'b000, "arm");
    cnt = 0;
    step(0, 1, 0, 3'b000, "det1");
    if (siren) cnt++;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 3'b000, "siren_run");
      if (siren) cnt++;
    end
    chk("siren_len8", cnt, 8);
    chk("ev_after_one", event_cnt, 1);
    chk("armed_after_siren", armed, 1);

    // Re-detection during siren cycle 5 extends the siren to 13 cycles.
    do_reset("r028");
    step(1, 0, 0, 3'b000, "arm");
    cnt = 0;
    step(0, 1, 0, 3'b000, "ext_det1");
    if (siren) cnt++;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 3'b000, "ext_run");
      if (siren) cnt++;
    end
    step(0, 1, 0, 3'b000, "ext_det2");
    if (siren) cnt++;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 3'b000, "ext_tail");
      if (siren) cnt++;
    end
    chk("siren_len13", cnt, 13);
    chk("ev_after_two", event_cnt, 2);

    // Correct code disarms.
    step(0, 0, 1, DEFAULT_CODE, "disarm");
    chk("disarm_armed", armed, 0);
    chk("disarm_det", det_reset, 1);

    // Three wrong codes lock out for LOCK_N cycles; correct code ignored.
    do_reset("r030");
    step(1, 0, 0, 3'b000, "arm");
    step(0, 0, 1, 3'b000, "wrong1");
    step(0, 0, 1, 3'b000, "wrong2");
    cnt = 0;
    step(0, 0, 1, 3'b000, "wrong3");
    if (locked && siren) cnt++;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 1, DEFAULT_CODE, "lock_ignore");
      if (locked && siren) cnt++;
    end
    step(0, 0, 0, 3'b000, "lock_exit");
    if (locked && siren) cnt++;
    chk("lock_len16", cnt, 16);
    chk("lock_exit_armed", armed, 1);
    chk("lock_exit_locked", locked, 0);

    // Correct code beats a simultaneous detection.
    do_reset("r031");
    step(1, 0, 0, 3'b000, "arm");
    step(0, 1, 1, DEFAULT_CODE, "code_vs_alarm");
    chk("cva_siren", siren, 0);
    chk("cva_ev", event_cnt, 0);
    chk("cva_armed", armed, 0);

    // Asynchronous reset mid-siren, then saturate the event counter.
    do_reset("r032");
    step(1, 0, 0, 3'b000, "arm");
    step(0, 1, 0, 3'b000, "det");
    step(0, 0, 0, 3'b000, "siren_mid");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_siren", siren, 0);
    chk("async_ev", event_cnt, 0);
    chk("async_det", det_reset, 1);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 3'b000, "rearm");
    for (int i = 0; i < 20; i++) step(0, 1, 0, 3'b000, "sat_det");
    chk("ev_saturated", event_cnt, 15);

    // Random traffic against the model.
    do_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      bit a, al, cv;
      logic [2:0] c;
      if (i == 300) do_reset("rnd_mid");
      a  = ($urandom_range(0, 3) == 0);
      al = ($urandom_range(0, 4) == 0);
      cv = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 2) == 0) ? DEFAULT_CODE : 3'($urandom_range(0, 7));
      step(a, al, cv, c, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
